// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, addresses the combinational instruction ROM,
// and registers the returned word (plus its address) for decode.
// Sequencing: IDLE -> RUN on Start, RUN -> DONE on Halt, DONE -> RUN on Start.
// In RUN the per-cycle priority is Halt > JumpEn > BranchEn > Stall > fetch.
// Optional feature macro: FETCH_CYCLE_COUNT_EN enables the RUN-cycle counter
// on CycleCount; without it CycleCount is tied to zero.
module fetch_unit #(
  parameter int             A          = 10,
  parameter int             W          = 9,
  parameter int             OFS        = 6,
  parameter logic [A-1:0]   START_ADDR = '0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             JumpEn,
  input  logic [A-1:0]     JumpAddr,
  input  logic             BranchEn,
  input  logic [OFS-1:0]   BranchOfs,
  input  logic [W-1:0]     InstIn,
  output logic [A-1:0]     InstAddress,
  output logic [W-1:0]     Ir,
  output logic [A-1:0]     IrPc,
  output logic             IrValid,
  output logic             Running,
  output logic             Done,
  output logic             AddrWrap,
  output logic [15:0]      CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;

  // Per-cycle actions decoded from state and inputs; at most one is high.
  logic           start_take;
  logic           halt_take;
  logic           jump_take;
  logic           branch_take;
  logic           fetch_take;

  logic [A-1:0]   pc;
  logic [A-1:0]   pc_next;
  logic [A-1:0]   pc_inc;
  logic [A-1:0]   ofs_ext;
  logic [A-1:0]   branch_target;
  logic           wrap_now;

  logic [W-1:0]   ir;
  logic [A-1:0]   ir_pc;
  logic           ir_valid;
  logic           addr_wrap;

  // State register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, regardless of block ordering.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and action decode, in RUN-priority order.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next  = state;
    start_take  = 1'b0;
    halt_take   = 1'b0;
    jump_take   = 1'b0;
    branch_take = 1'b0;
    fetch_take  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_next = S_RUN;
          start_take = 1'b1;
        end
      end
      S_RUN: begin
        if (Halt) begin
          state_next = S_DONE;
          halt_take  = 1'b1;
        end else if (JumpEn) begin
          jump_take = 1'b1;
        end else if (BranchEn) begin
          branch_take = 1'b1;
        end else if (!Stall) begin
          fetch_take = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Address arithmetic: sequential increment and PC-relative branch target,
  // both naturally modulo 2^A by truncation.
  always_comb begin
    pc_inc        = pc + A'(1);
    ofs_ext       = A'($signed(BranchOfs));
    branch_target = ir_pc + ofs_ext;
    wrap_now      = fetch_take && (pc == '1);
  end

  // Next PC selection; redirects take precedence over sequential fetch.
  always_comb begin
    pc_next = pc;
    if (start_take) begin
      pc_next = START_ADDR;
    end else if (jump_take) begin
      pc_next = JumpAddr;
    end else if (branch_take) begin
      pc_next = branch_target;
    end else if (fetch_take) begin
      pc_next = pc_inc;
    end
  end

  // Program counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc <= START_ADDR;
    end else begin
      pc <= pc_next;
    end
  end

  // Instruction register and its fetch address; only a plain fetch loads them.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ir    <= '0;
      ir_pc <= '0;
    end else if (fetch_take) begin
      ir    <= InstIn;
      ir_pc <= pc;
    end
  end

  // Valid flag: set by a fetch, cleared by start, halt and any redirect
  // (the redirect bubble), held across stalls and outside RUN.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ir_valid <= 1'b0;
    end else if (fetch_take) begin
      ir_valid <= 1'b1;
    end else if (start_take || halt_take || jump_take || branch_take) begin
      ir_valid <= 1'b0;
    end
  end

  // Sticky wrap flag: set when sequential fetch rolls 2^A-1 over to 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_wrap <= 1'b0;
    end else if (start_take) begin
      addr_wrap <= 1'b0;
    end else if (wrap_now) begin
      addr_wrap <= 1'b1;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cycle_cnt;

  // RUN-cycle counter: counts every RUN edge including stalls and the halt
  // edge itself, saturates at all-ones, cleared by Start, frozen otherwise.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycle_cnt <= '0;
    end else if (start_take) begin
      cycle_cnt <= '0;
    end else if ((state == S_RUN) && (cycle_cnt != 16'hFFFF)) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = 16'd0;
`endif

  assign InstAddress = pc;
  assign Ir          = ir;
  assign IrPc        = ir_pc;
  assign IrValid     = ir_valid;
  assign AddrWrap    = addr_wrap;
  assign Running     = (state == S_RUN);
  assign Done        = (state == S_DONE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed vector table for the documented sequences, hand-written sequences
// for halt/counter and asynchronous reset, and a randomized run compared
// against a behavioural model driven by the same inputs.
module tb_fetch_unit;

  localparam int A = 10;
  localparam int W = 9;
  localparam int OFS = 6;
  localparam int DEPTH = 1 << A;

  logic           Clk;
  logic           Reset_n;
  logic           Start;
  logic           Stall;
  logic           Halt;
  logic           JumpEn;
  logic [A-1:0]   JumpAddr;
  logic           BranchEn;
  logic [OFS-1:0] BranchOfs;
  logic [W-1:0]   InstIn;
  logic [A-1:0]   InstAddress;
  logic [W-1:0]   Ir;
  logic [A-1:0]   IrPc;
  logic           IrValid;
  logic           Running;
  logic           Done;
  logic           AddrWrap;
  logic [15:0]    CycleCount;

  logic [W-1:0]   rom [DEPTH];

  int checks = 0;
  int failures = 0;

  // Behavioural model state (plain integers and flags).
  bit m_running, m_done, m_valid, m_wrap;
  int m_pc, m_ir, m_irpc, m_cnt;

  fetch_unit #(.A(A), .W(W), .OFS(OFS), .START_ADDR('0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .JumpEn(JumpEn), .JumpAddr(JumpAddr), .BranchEn(BranchEn),
    .BranchOfs(BranchOfs), .InstIn(InstIn), .InstAddress(InstAddress),
    .Ir(Ir), .IrPc(IrPc), .IrValid(IrValid), .Running(Running), .Done(Done),
    .AddrWrap(AddrWrap), .CycleCount(CycleCount)
  );

  assign InstIn = rom[InstAddress];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_count(input int cnt);
`ifdef FETCH_CYCLE_COUNT_EN
    return cnt;
`else
    return 0 * cnt;
`endif
  endfunction

  task automatic clear_inputs();
    Start = 0; Stall = 0; Halt = 0; JumpEn = 0; JumpAddr = '0;
    BranchEn = 0; BranchOfs = '0;
  endtask

  task automatic model_reset();
    m_running = 0; m_done = 0; m_valid = 0; m_wrap = 0;
    m_pc = 0; m_ir = 0; m_irpc = 0; m_cnt = 0;
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_step();
    int ofs;
    if (!m_running) begin
      if (Start) begin
        m_running = 1; m_done = 0; m_pc = 0; m_valid = 0; m_wrap = 0; m_cnt = 0;
      end
    end else begin
      if (m_cnt < 65535) m_cnt++;
      if (Halt) begin
        m_running = 0; m_done = 1; m_valid = 0;
      end else if (JumpEn) begin
        m_pc = int'(JumpAddr); m_valid = 0;
      end else if (BranchEn) begin
        ofs = int'(BranchOfs);
        if (ofs >= (1 << (OFS - 1))) ofs -= (1 << OFS);
        m_pc = (m_irpc + ofs + DEPTH) % DEPTH; m_valid = 0;
      end else if (!Stall) begin
        m_ir = int'(rom[m_pc]); m_irpc = m_pc; m_valid = 1;
        if (m_pc == DEPTH - 1) m_wrap = 1;
        m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"},    32'(InstAddress), 32'(m_pc));
    check({tag, ".ir"},    32'(Ir),          32'(m_ir));
    check({tag, ".irpc"},  32'(IrPc),        32'(m_irpc));
    check({tag, ".valid"}, 32'(IrValid),     32'(m_valid));
    check({tag, ".run"},   32'(Running),     32'(m_running));
    check({tag, ".done"},  32'(Done),        32'(m_done));
    check({tag, ".wrap"},  32'(AddrWrap),    32'(m_wrap));
    check({tag, ".cnt"},   32'(CycleCount),  32'(exp_count(m_cnt)));
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset_n = 0;
    repeat (2) @(negedge Clk);
    Reset_n = 1;
    model_reset();
    #1;
  endtask

  typedef struct {
    bit st, sl, ht, je;
    int ja;
    bit be;
    int ofs;
    int pc, irpc;
    bit valid, run, dn, wr;
  } vec_t;

  function automatic vec_t mk(input bit st, sl, ht, je, input int ja, input bit be,
                              input int ofs, input int pc, irpc,
                              input bit valid, run, dn, wr);
    vec_t r;
    r.st = st; r.sl = sl; r.ht = ht; r.je = je; r.ja = ja; r.be = be; r.ofs = ofs;
    r.pc = pc; r.irpc = irpc; r.valid = valid; r.run = run; r.dn = dn; r.wr = wr;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    Reset_n = 1;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) rom[i] = W'($urandom_range(1, (1 << W) - 1));
    rom[0] = 9'h011; rom[1] = 9'h022; rom[2] = 9'h033; rom[3] = 9'h044;

    //            st sl ht je  ja   be ofs  pc    irpc v  r  d  w
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  0,    0,    0, 0, 0, 0)); // idle
    vecs.push_back(mk(1, 0, 0, 0, 0,    0, 0,  0,    0,    0, 1, 0, 0)); // start
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  1,    0,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  2,    1,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  3,    2,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  4,    3,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  5,    4,    1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  5,    4,    1, 1, 0, 0)); // stall x3
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  5,    4,    1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0,    0, 0,  5,    4,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  6,    5,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  7,    6,    1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,    0, 0,  8,    7,    1, 1, 0, 0)); // start ignored
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  9,    8,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  10,   9,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  11,   10,   1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    1, 60, 6,    10,   0, 1, 0, 0)); // branch -4
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  7,    6,    1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 100,  1, 5,  100,  6,    0, 1, 0, 0)); // jump wins
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  101,  100,  1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 200,  0, 0,  200,  100,  0, 1, 0, 0)); // jump beats stall
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  201,  200,  1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1023, 0, 0,  1023, 200,  0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  0,    1023, 1, 1, 0, 1)); // wrap
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  1,    0,    1, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0,    0, 0,  1,    0,    0, 0, 1, 1)); // halt
    vecs.push_back(mk(0, 0, 0, 1, 50,   1, 3,  1,    0,    0, 0, 1, 1)); // ignored in DONE
    vecs.push_back(mk(1, 0, 0, 0, 0,    0, 0,  0,    0,    0, 1, 0, 0)); // restart
    vecs.push_back(mk(0, 0, 0, 0, 0,    0, 0,  1,    0,    1, 1, 0, 0));

    // Reset state.
    do_reset();
    compare_model("reset");

    // Directed vector table.
    foreach (vecs[i]) begin
      Start = vecs[i].st; Stall = vecs[i].sl; Halt = vecs[i].ht;
      JumpEn = vecs[i].je; JumpAddr = A'(vecs[i].ja);
      BranchEn = vecs[i].be; BranchOfs = OFS'(vecs[i].ofs);
      tick();
      check($sformatf("vec%0d.pc", i),    32'(InstAddress), 32'(vecs[i].pc));
      check($sformatf("vec%0d.irpc", i),  32'(IrPc),        32'(vecs[i].irpc));
      check($sformatf("vec%0d.valid", i), 32'(IrValid),     32'(vecs[i].valid));
      check($sformatf("vec%0d.run", i),   32'(Running),     32'(vecs[i].run));
      check($sformatf("vec%0d.done", i),  32'(Done),        32'(vecs[i].dn));
      check($sformatf("vec%0d.wrap", i),  32'(AddrWrap),    32'(vecs[i].wr));
      if (vecs[i].valid)
        check($sformatf("vec%0d.ir", i), 32'(Ir), 32'(rom[vecs[i].irpc]));
    end
    clear_inputs();

    // Halt on the 20th RUN cycle: counter reads 20, then holds in DONE.
    do_reset();
    Start = 1; tick(); Start = 0;
    repeat (19) tick();
    Halt = 1; tick(); Halt = 0;
    check("halt20.done",  32'(Done),        32'd1);
    check("halt20.run",   32'(Running),     32'd0);
    check("halt20.valid", 32'(IrValid),     32'd0);
    check("halt20.pc",    32'(InstAddress), 32'd19);
    check("halt20.cnt",   32'(CycleCount),  32'(exp_count(20)));
    repeat (3) tick();
    check("halt20.cnt_hold", 32'(CycleCount), 32'(exp_count(20)));
    Start = 1; tick(); Start = 0;
    check("restart.pc",   32'(InstAddress), 32'd0);
    check("restart.done", 32'(Done),        32'd0);
    check("restart.cnt",  32'(CycleCount),  32'd0);
    check("restart.wrap", 32'(AddrWrap),    32'd0);

    // Asynchronous reset between edges, with wrap and Ir populated.
    do_reset();
    Start = 1; tick(); Start = 0;
    JumpEn = 1; JumpAddr = A'(1022); tick(); JumpEn = 0;
    repeat (4) tick();
    check("prerst.wrap", 32'(AddrWrap), 32'd1);
    #2;
    Reset_n = 0;
    #1;
    check("asyncrst.pc",    32'(InstAddress), 32'd0);
    check("asyncrst.ir",    32'(Ir),          32'd0);
    check("asyncrst.irpc",  32'(IrPc),        32'd0);
    check("asyncrst.valid", 32'(IrValid),     32'd0);
    check("asyncrst.run",   32'(Running),     32'd0);
    check("asyncrst.done",  32'(Done),        32'd0);
    check("asyncrst.wrap",  32'(AddrWrap),    32'd0);
    check("asyncrst.cnt",   32'(CycleCount),  32'd0);
    @(negedge Clk);
    Reset_n = 1;
    model_reset();
    tick();
    compare_model("postrst_idle");

    // Randomized run against the behavioural model.
    for (int c = 0; c < 3000; c++) begin
      Start    = ($urandom_range(0, 99) < 8);
      Halt     = ($urandom_range(0, 99) < 2);
      JumpEn   = ($urandom_range(0, 99) < 6);
      JumpAddr = ($urandom_range(0, 3) == 0) ? A'($urandom_range(1018, 1023))
                                             : A'($urandom_range(0, DEPTH - 1));
      BranchEn  = ($urandom_range(0, 99) < 8);
      BranchOfs = OFS'($urandom_range(0, (1 << OFS) - 1));
      Stall     = ($urandom_range(0, 99) < 25);
      model_step();
      tick();
      compare_model($sformatf("rand%0d", c));
    end
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
